// File: rtl/cpu8_bus_pkg.sv
// cpu8_bus_pkg: shared widths and the bus-master state encoding.
package cpu8_bus_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int RAM_DEPTH = 2 ** ADDR_W;
  typedef enum logic [2:0] {IDLE, LD_WAIT, LD_WR, LD_CHK, DP_RD, DP_HOLD, DONE} state_t;
endpackage

// File: rtl/ram_bus_drv.sv
// ram_bus_drv: tri-state driver for the shared RAM data bus.
module ram_bus_drv #(
  parameter int W = 8
) (
  input  logic         oe,
  input  logic [W-1:0] d,
  inout  wire  [W-1:0] bus
);
  assign bus = oe ? d : {W{1'bz}};
endmodule

// File: rtl/ram_bus_master.sv
// ram_bus_master: load/dump bus initiator for the 16x8 shared-bus RAM.
// Define RAM_BUS_MASTER_VERIFY_EN to read back every loaded byte and flag mismatches on err.
module ram_bus_master #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int START_ADDR = 0,
  parameter int XFER_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_in,
  output logic              ram_out,
  output logic [ADDR_W-1:0] ram_add_4,
  inout  wire  [DATA_W-1:0] ram_bus_8
);
  import cpu8_bus_pkg::*;
  localparam logic [ADDR_W-1:0] A0 = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(XFER_LEN - 1);
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr, count;
  logic [DATA_W-1:0] wr_reg;
  logic adv;
  always_comb begin
    state_nx = state;
    adv = 1'b0;
    case (state)
      IDLE:    state_nx = start_load ? LD_WAIT : start_dump ? DP_RD : IDLE;
      LD_WAIT: state_nx = in_valid ? LD_WR : LD_WAIT;
`ifdef RAM_BUS_MASTER_VERIFY_EN
      LD_WR:   state_nx = LD_CHK;
      LD_CHK: begin
        adv = count != LAST;
        state_nx = adv ? LD_WAIT : DONE;
      end
`else
      LD_WR: begin
        adv = count != LAST;
        state_nx = adv ? LD_WAIT : DONE;
      end
`endif
      DP_RD:   state_nx = DP_HOLD;
      DP_HOLD: begin
        adv = out_ready && count != LAST;
        state_nx = !out_ready ? DP_HOLD : adv ? DP_RD : DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= A0;
      count <= '0;
      wr_reg <= '0;
      out_data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (start_load || start_dump)) begin
        addr <= A0;
        count <= '0;
      end else if (adv) begin
        addr <= addr + 1'b1;
        count <= count + 1'b1;
      end
      if (state == LD_WAIT && in_valid) wr_reg <= in_data;
      if (state == DP_RD) out_data <= ram_bus_8;
    end
  end
`ifdef RAM_BUS_MASTER_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (state == LD_CHK && ram_bus_8 != wr_reg) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
  assign in_ready = state == LD_WAIT;
  assign out_valid = state == DP_HOLD;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign ram_in = state == LD_WR;
  assign ram_out = state == DP_RD || state == LD_CHK;
  assign ram_add_4 = addr;
  ram_bus_drv #(.W(DATA_W)) u_drv (.oe(ram_in), .d(wr_reg), .bus(ram_bus_8));
endmodule
